multi_chan_sync: RTL and testbench

Multi-channel, parametrised successor to the single-bit synchroniser. It brings CHANNELS independent asynchronous level signals into the CLK domain through an N-stage flop chain per channel. It then debounces each synchronised level with a stability filter and produces one-cycle rise and fall pulses on the filtered level. It sits at every clock-domain boundary where slow control or status levels cross, such as enables, busy flags and external pins, and replaces ad-hoc synchroniser plus edge-detect pairs.

---
 rtl/sync_pkg.sv | 17 +
 rtl/sync_filter_chan.sv | 64 ++++++
 rtl/multi_chan_sync.sv | 54 +++++
 tb/tb_multi_chan_sync.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/sync_pkg.sv
// Shared helpers for the multi-channel level synchroniser: counter sizing
// and parameter legality used at elaboration.
package sync_pkg;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic bit params_legal(input int channels, input int num_stages,
                                      input int filter_len);
    return (channels >= 1) && (num_stages >= 2) && (filter_len >= 1);
  endfunction

endpackage

// File: rtl/sync_filter_chan.sv
// One channel: flop-chain synchroniser, stability filter on the synchronised
// level, and registered one-cycle rise/fall pulses on the filtered level.
module sync_filter_chan
  import sync_pkg::*;
#(
  parameter int   NUM_STAGES = 2,
  parameter int   FILTER_LEN = 3,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic CLK,
  input  logic RST,
  input  logic lvl,
  output logic sync,
  output logic filt,
  output logic rise,
  output logic fall,
  output logic upd
);

  localparam int CNT_W = clog2(FILTER_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_LEN - 1);

  (* ASYNC_REG = "TRUE" *) logic [NUM_STAGES-1:0] chain;
  logic [CNT_W-1:0] cnt;
  logic             filt_q;
  logic             rise_q;
  logic             fall_q;
  logic             synced;
  logic             differ;
  logic             hit;

  // Synchroniser chain: pure shift register, stage 0 samples the async level
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) chain <= {NUM_STAGES{RESET_VAL}};
    else      chain <= {chain[NUM_STAGES-2:0], lvl};
  end

  assign synced = chain[NUM_STAGES-1];
  assign differ = synced != filt_q;
  assign hit    = differ && (cnt == CNT_LAST);

  // Filter stage: FILT follows only after FILTER_LEN consecutive differing samples
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      cnt    <= '0;
      filt_q <= RESET_VAL;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      rise_q <= hit && synced;
      fall_q <= hit && !synced;
      if (!differ || hit) cnt <= '0;
      else                cnt <= cnt + CNT_W'(1);
      if (hit) filt_q <= synced;
    end
  end

  assign sync = synced;
  assign filt = filt_q;
  assign rise = rise_q;
  assign fall = fall_q;
  assign upd  = hit;

endmodule

// File: rtl/multi_chan_sync.sv
// CHANNELS independent synchroniser/debounce/edge-detect channels plus a
// registered "any channel changed" flag built from the same update events.
module multi_chan_sync
  import sync_pkg::*;
#(
  parameter int   CHANNELS   = 4,
  parameter int   NUM_STAGES = 2,
  parameter int   FILTER_LEN = 3,
  parameter logic RESET_VAL  = 1'b0
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [CHANNELS-1:0] ASYNC,
  output logic [CHANNELS-1:0] SYNC,
  output logic [CHANNELS-1:0] FILT,
  output logic [CHANNELS-1:0] RISE,
  output logic [CHANNELS-1:0] FALL,
  output logic                ANY_CHG
);

  logic [CHANNELS-1:0] upd;
  logic                any_q;

  if (!params_legal(CHANNELS, NUM_STAGES, FILTER_LEN)) begin : g_bad_params
    $error("multi_chan_sync: illegal parameters CHANNELS=%0d NUM_STAGES=%0d FILTER_LEN=%0d",
           CHANNELS, NUM_STAGES, FILTER_LEN);
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    sync_filter_chan #(
      .NUM_STAGES(NUM_STAGES),
      .FILTER_LEN(FILTER_LEN),
      .RESET_VAL (RESET_VAL)
    ) u_chan (
      .CLK (CLK),
      .RST (RST),
      .lvl (ASYNC[i]),
      .sync(SYNC[i]),
      .filt(FILT[i]),
      .rise(RISE[i]),
      .fall(FALL[i]),
      .upd (upd[i])
    );
  end

  // Registered alongside RISE/FALL so it lands in the same cycle as the pulses
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) any_q <= 1'b0;
    else      any_q <= |upd;
  end

  assign ANY_CHG = any_q;

endmodule

// File: tb/tb_multi_chan_sync.sv
// Bench for multi_chan_sync: table vectors, hand sequences for reset and
// parameter corners, and random levels against a sample-history reference model.
module tb_multi_chan_sync;

  logic       CLK = 1'b0;
  logic       RST0 = 1'b0, RST1 = 1'b0;
  logic [3:0] A0 = 4'hF, A1 = 4'hF;
  logic [3:0] S0, F0, R0, FL0, S1, F1, R1, FL1;
  logic       AC0, AC1;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  multi_chan_sync #(.CHANNELS(4), .NUM_STAGES(2), .FILTER_LEN(3), .RESET_VAL(1'b0)) dut0 (
    .CLK(CLK), .RST(RST0), .ASYNC(A0), .SYNC(S0), .FILT(F0), .RISE(R0), .FALL(FL0),
    .ANY_CHG(AC0));

  multi_chan_sync #(.CHANNELS(4), .NUM_STAGES(3), .FILTER_LEN(1), .RESET_VAL(1'b1)) dut1 (
    .CLK(CLK), .RST(RST1), .ASYNC(A1), .SYNC(S1), .FILT(F1), .RISE(R1), .FALL(FL1),
    .ANY_CHG(AC1));

  task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: output values after edge e since reset release
  int         ns [2] = '{2, 3};
  int         fl [2] = '{3, 1};
  logic       rv [2] = '{1'b0, 1'b1};
  int         ecnt [2];
  logic [3:0] hist [2][4096];
  logic [3:0] m_sync [2], m_filt [2], m_rise [2], m_fall [2];
  logic       m_any [2];

  function automatic logic sync_at(input int k, input int x, input int i);
    if (x < ns[k]) return rv[k];
    return hist[k][(x - ns[k] + 1) % 4096][i];
  endfunction

  task automatic model_step(input int k, input logic rst, input logic [3:0] a);
    logic [3:0] nr, nf;
    bit all_diff;
    if (!rst) begin
      ecnt[k]   = 0;
      m_sync[k] = {4{rv[k]}};
      m_filt[k] = {4{rv[k]}};
      m_rise[k] = 4'h0;
      m_fall[k] = 4'h0;
      m_any[k]  = 1'b0;
      return;
    end
    ecnt[k]++;
    hist[k][ecnt[k] % 4096] = a;
    nr = 4'h0;
    nf = 4'h0;
    for (int i = 0; i < 4; i++) begin
      all_diff = 1'b1;
      for (int j = 1; j <= fl[k]; j++)
        if (sync_at(k, ecnt[k] - j, i) == m_filt[k][i]) all_diff = 1'b0;
      if (all_diff) begin
        m_filt[k][i] = ~m_filt[k][i];
        if (m_filt[k][i]) nr[i] = 1'b1;
        else              nf[i] = 1'b1;
      end
    end
    for (int i = 0; i < 4; i++) m_sync[k][i] = sync_at(k, ecnt[k], i);
    m_rise[k] = nr;
    m_fall[k] = nf;
    m_any[k]  = |(nr | nf);
  endtask

  always @(posedge CLK or negedge RST0) model_step(0, RST0, A0);
  always @(posedge CLK or negedge RST1) model_step(1, RST1, A1);

  always @(posedge CLK) begin
    #2;
    chk("m0_sync", S0, m_sync[0]);
    chk("m0_filt", F0, m_filt[0]);
    chk("m0_rise", R0, m_rise[0]);
    chk("m0_fall", FL0, m_fall[0]);
    chk("m0_any", {3'b0, AC0}, {3'b0, m_any[0]});
    chk("m1_sync", S1, m_sync[1]);
    chk("m1_filt", F1, m_filt[1]);
    chk("m1_rise", R1, m_rise[1]);
    chk("m1_fall", FL1, m_fall[1]);
    chk("m1_any", {3'b0, AC1}, {3'b0, m_any[1]});
  end

  typedef struct {
    logic [3:0] a;
    int         n;
    logic [3:0] s, f, r, fa;
    logic       any;
  } vec_t;

  vec_t tbl [24];

  task automatic chk_all0(input string tag, input logic [3:0] s, input logic [3:0] f,
                          input logic [3:0] r, input logic [3:0] fa, input logic any);
    chk({tag, "_sync"}, S0, s);
    chk({tag, "_filt"}, F0, f);
    chk({tag, "_rise"}, R0, r);
    chk({tag, "_fall"}, FL0, fa);
    chk({tag, "_any"}, {3'b0, AC0}, {3'b0, any});
  endtask

  initial begin
    tbl[0]  = '{4'hF, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[1]  = '{4'hF, 1, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[2]  = '{4'hF, 2, 4'hF, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[3]  = '{4'hF, 1, 4'hF, 4'hF, 4'hF, 4'h0, 1'b1};
    tbl[4]  = '{4'hF, 1, 4'hF, 4'hF, 4'h0, 4'h0, 1'b0};
    tbl[5]  = '{4'h0, 5, 4'h0, 4'h0, 4'h0, 4'hF, 1'b1};
    tbl[6]  = '{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[7]  = '{4'h5, 4, 4'h5, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[8]  = '{4'h5, 1, 4'h5, 4'h5, 4'h5, 4'h0, 1'b1};
    tbl[9]  = '{4'h5, 1, 4'h5, 4'h5, 4'h0, 4'h0, 1'b0};
    tbl[10] = '{4'h3, 4, 4'h3, 4'h5, 4'h0, 4'h0, 1'b0};
    tbl[11] = '{4'h3, 1, 4'h3, 4'h3, 4'h2, 4'h4, 1'b1};
    tbl[12] = '{4'h3, 1, 4'h3, 4'h3, 4'h0, 4'h0, 1'b0};
    tbl[13] = '{4'h0, 6, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[14] = '{4'h2, 2, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[15] = '{4'h0, 1, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[16] = '{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[17] = '{4'h0, 3, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[18] = '{4'h2, 4, 4'h2, 4'h0, 4'h0, 4'h0, 1'b0};
    tbl[19] = '{4'h0, 1, 4'h2, 4'h2, 4'h2, 4'h0, 1'b1};
    tbl[20] = '{4'h0, 1, 4'h0, 4'h2, 4'h0, 4'h0, 1'b0};
    tbl[21] = '{4'h0, 2, 4'h0, 4'h2, 4'h0, 4'h0, 1'b0};
    tbl[22] = '{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h2, 1'b1};
    tbl[23] = '{4'h0, 1, 4'h0, 4'h0, 4'h0, 4'h0, 1'b0};

    // Reset held with all inputs high: everything stays at reset values
    repeat (3) @(posedge CLK);
    #1 chk_all0("rst_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    chk("rst1_sync", S1, 4'hF);
    chk("rst1_filt", F1, 4'hF);
    @(negedge CLK);
    RST0 = 1'b1;

    for (int v = 0; v < 24; v++) begin
      A0 = tbl[v].a;
      repeat (tbl[v].n) @(posedge CLK);
      #1;
      chk_all0($sformatf("vec%0d", v), tbl[v].s, tbl[v].f, tbl[v].r, tbl[v].fa, tbl[v].any);
      @(negedge CLK);
    end

    // Reset while channel 0 counts up and a fall is pending on channel 2
    A0 = 4'b0100;
    repeat (6) @(posedge CLK);
    #1 chk("mid_pre_filt", F0, 4'b0100);
    @(negedge CLK);
    A0 = 4'b0001;
    repeat (4) @(posedge CLK);
    #1 chk_all0("mid_pend", 4'b0001, 4'b0100, 4'h0, 4'h0, 1'b0);
    RST0 = 1'b0;
    #1 chk_all0("mid_rst", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    repeat (2) @(posedge CLK);
    #1 chk_all0("mid_hold", 4'h0, 4'h0, 4'h0, 4'h0, 1'b0);
    @(negedge CLK);
    RST0 = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      @(posedge CLK);
      #1 chk_all0($sformatf("mid_rel%0d", e), (e >= 2) ? 4'b0001 : 4'h0, 4'h0, 4'h0, 4'h0,
                  1'b0);
    end
    @(posedge CLK);
    #1 chk_all0("mid_rel5", 4'b0001, 4'b0001, 4'b0001, 4'h0, 1'b1);

    // Corner instance: 3 stages, no filtering, reset value one
    @(negedge CLK);
    RST1 = 1'b1;
    repeat (4) @(posedge CLK);
    #1 chk("c_idle_filt", F1, 4'hF);
    chk("c_idle_fall", FL1, 4'h0);
    @(negedge CLK);
    A1 = 4'hE;
    repeat (2) @(posedge CLK);
    #1 chk("c_e2_sync", S1, 4'hF);
    @(posedge CLK);
    #1 chk("c_e3_sync", S1, 4'hE);
    chk("c_e3_filt", F1, 4'hF);
    @(posedge CLK);
    #1 chk("c_e4_filt", F1, 4'hE);
    chk("c_e4_fall", FL1, 4'h1);
    chk("c_e4_any", {3'b0, AC1}, 4'h1);
    @(posedge CLK);
    #1 chk("c_e5_fall", FL1, 4'h0);

    // Random slow levels with occasional resets, checked by the model
    for (int c = 0; c < 1500; c++) begin
      @(negedge CLK);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(4) == 0) A0[i] = ~A0[i];
        if ($urandom_range(2) == 0) A1[i] = ~A1[i];
      end
      RST0 = ($urandom_range(149) != 0);
      RST1 = ($urandom_range(149) != 0);
    end
    @(negedge CLK);
    RST0 = 1'b1;
    RST1 = 1'b1;
    repeat (3) @(posedge CLK);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
